led_pattern_engine: RTL
=======================

// Module: led_pattern_engine
// PURPOSE
//  Parametrised LED pattern generator; successor to the two-half shift block.
//  Four step modes: rotate, mirror, bounce, fill.
//  Steps are paced by i_valid strobes through a programmable prescaler.
//  Sits between the tick/switch front-end and the board LED pins.
// PARAMETERS
//  NB_LED  4  LED count; even, >= 4; H = NB_LED/2 is the half width
//  NB_DIV  4  prescaler width; a step occurs every (i_div+1) i_valid strobes
// PORTS
//  clock      in   1       system clock, rising edge
//  i_reset_n  in   1       reset, asynchronous, active-low
//  i_valid    in   1       advance strobe, one cycle per tick
//  i_div      in   NB_DIV  prescale: i_valid strobes per step, minus 1
//  i_mode     in   2       0 ROTATE, 1 MIRROR, 2 BOUNCE, 3 FILL
//  i_dir      in   1       direction, used by ROTATE/MIRROR/FILL
//  o_led      out  NB_LED  current pattern (registered)
//  o_step     out  1       1-cycle pulse in the cycle o_led takes a step value
// BEHAVIOUR
//  Reset: o_led=0..01, mode_q=0, div_cnt=0, bounce_dir=UP, fill_ph=FILL, o_step=0.
//  Reset assertion mid-run returns to the reset values immediately (async).
//  Prescaler:
//   - i_valid && div_cnt>=i_div -> step=1, div_cnt<=0.
//   - Else i_valid -> div_cnt++.
//   - ">=" applies when i_div is lowered below div_cnt.
//  Step latency: o_led and o_step update on the edge sampling the qualifying i_valid.
//  Mode change: i_mode != mode_q at a clock edge has priority over the step:
//   - o_led <= seed(i_mode), mode_q <= i_mode, div_cnt <= 0.
//   - bounce_dir <= UP, fill_ph <= FILL, no step that cycle.
//  Seeds: ROTATE 0..01; MIRROR bit0|bit NB_LED-1; BOUNCE 0..01; FILL all-zero.
//  ROTATE:
//   - i_dir=1: rotate toward MSB, MSB wraps to bit0.
//   - i_dir=0: rotate toward LSB.
//  MIRROR (L=o_led[H-1:0], U=o_led[NB_LED-1:H]):
//   - i_dir=1 inward: L rotates toward H-1, U rotates toward H.
//   - i_dir=0 outward: reverse of inward.
//   - Each half wraps within itself; U is always the bit-mirror of L.
//  BOUNCE:
//   - Single lit LED moves per bounce_dir; i_dir is ignored.
//   - Arriving at bit NB_LED-1 sets bounce_dir=DOWN; arriving at bit0 sets UP.
//   - Period 2*(NB_LED-1) steps.
//  FILL, i_dir=1 (bar grows from LSB):
//   - Phase FILL: o_led <= {o_led[NB_LED-2:0],1}.
//   - Phase CLEAR: o_led <= {o_led[NB_LED-2:0],0}.
//  FILL, i_dir=0 (bar grows from MSB): shift-in from the MSB side instead.
//  FILL phase flips: all-ones reached -> CLEAR; all-zero reached -> FILL.
//  FILL period 2*NB_LED steps.
//  i_dir changes take effect on the next step; no reseed.
//  Illegal or one-hot-broken states are not possible from reset.
//  No extra recovery logic is required.
// CONFIGURATION
//  LED_WRAP_FLAG_EN defined:
//   - Adds port o_wrap (out, 1).
//   - o_wrap is a 1-cycle pulse, coincident with o_step, when the step returns o_led to the mode seed.
//   - o_wrap resets to 0 and is never set on a mode-change reseed.
//  LED_WRAP_FLAG_EN undefined: no o_wrap port and no wrap compare logic; all other behaviour is identical.
// TESTING (NB_LED=4, NB_DIV=4)
//  1. Reset, i_mode=0, i_dir=1, i_div=0, 5 strobes -> o_led 0010,0100,1000,0001,0010; o_step each strobe.
//  2. i_div=2, ROTATE -> step only on every 3rd strobe; lower i_div to 0 while div_cnt=2 -> next strobe steps.
//  3. i_mode=1, i_dir=1 -> seed 1001; steps 0110,1001,0110; i_dir=0 from seed -> 0110.
//  4. i_mode=2 -> seed 0001; steps 0010,0100,1000,0100,0010,0001 (o_wrap on the 0001 step if LED_WRAP_FLAG_EN).
//  5. i_mode=3, i_dir=1 -> seed 0000; steps 0001,0011,0111,1111,1110,1100,1000,0000.
//  6. Mode change coincident with a qualifying strobe -> reseed only, no o_step.
//     i_reset_n low mid-BOUNCE (DOWN) -> o_led=0001 asynchronously; next steps go UP.

Source files
------------

// File: rtl/led_pattern_engine.sv
// LED pattern engine: rotate, mirror, bounce and fill patterns paced by
// i_valid strobes through a programmable prescaler.
// Ports: clock, i_reset_n (async, active-low), i_valid (advance strobe),
//   i_div (strobes per step minus 1), i_mode (0 rot,1 mir,2 bnc,3 fill),
//   i_dir (direction), o_led (pattern), o_step (step pulse).
// Optional: LED_WRAP_FLAG_EN adds o_wrap, pulsed when a step lands on
//   the seed pattern of the current mode.
module led_pattern_engine #(
    parameter int NB_LED = 4,
    parameter int NB_DIV = 4
) (
    input  logic              clock,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [NB_DIV-1:0] i_div,
    input  logic [1:0]        i_mode,
    input  logic              i_dir,
    output logic [NB_LED-1:0] o_led,
    output logic              o_step
`ifdef LED_WRAP_FLAG_EN
    ,
    output logic              o_wrap
`endif
);

    localparam int H = NB_LED / 2;

    localparam logic [1:0] M_ROTATE = 2'd0;
    localparam logic [1:0] M_MIRROR = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;
    localparam logic [1:0] M_FILL   = 2'd3;

    localparam logic [NB_LED-1:0] ONE = {{(NB_LED-1){1'b0}}, 1'b1};
    localparam logic [NB_LED-1:0] ENDS = ONE | (ONE << (NB_LED-1));
    localparam logic [NB_DIV-1:0] CNT_ONE = {{(NB_DIV-1){1'b0}}, 1'b1};

    typedef enum logic {UP, DOWN} bounce_dir_t;
    typedef enum logic {FILL, CLEAR} fill_ph_t;

    logic [1:0]        mode_q, mode_d;
    logic [NB_DIV-1:0] div_cnt, cnt_d;
    bounce_dir_t       bdir_q, bdir_d;
    fill_ph_t          fph_q, fph_d;
    logic [NB_LED-1:0] led_d, step_led;
    logic [H-1:0]      lo, hi;
    logic              step_d;
    logic              fill_bit;
`ifdef LED_WRAP_FLAG_EN
    logic              wrap_d;
`endif

    function automatic logic [NB_LED-1:0] seed(input logic [1:0] m);
        logic [NB_LED-1:0] s;
        case (m)
            M_MIRROR: s = ENDS;
            M_FILL:   s = '0;
            default:  s = ONE;
        endcase
        return s;
    endfunction

    // Candidate pattern for a step in the current mode.
    always_comb begin
        lo       = o_led[H-1:0];
        hi       = o_led[NB_LED-1:H];
        fill_bit = (fph_q == FILL);
        step_led = o_led;
        case (mode_q)
            M_ROTATE: begin
                if (i_dir) step_led = {o_led[NB_LED-2:0], o_led[NB_LED-1]};
                else       step_led = {o_led[0], o_led[NB_LED-1:1]};
            end
            M_MIRROR: begin
                // Halves rotate in opposite directions so U mirrors L.
                if (i_dir) step_led = {hi[0], hi[H-1:1], lo[H-2:0], lo[H-1]};
                else       step_led = {hi[H-2:0], hi[H-1], lo[0], lo[H-1:1]};
            end
            M_BOUNCE: begin
                if (bdir_q == UP) step_led = {o_led[NB_LED-2:0], 1'b0};
                else              step_led = {1'b0, o_led[NB_LED-1:1]};
            end
            default: begin
                if (i_dir) step_led = {o_led[NB_LED-2:0], fill_bit};
                else       step_led = {fill_bit, o_led[NB_LED-1:1]};
            end
        endcase
    end

    always_comb begin
        led_d  = o_led;
        mode_d = mode_q;
        cnt_d  = div_cnt;
        bdir_d = bdir_q;
        fph_d  = fph_q;
        step_d = 1'b0;
`ifdef LED_WRAP_FLAG_EN
        wrap_d = 1'b0;
`endif
        if (i_mode != mode_q) begin
            // Reseed wins over any step due this cycle.
            led_d  = seed(i_mode);
            mode_d = i_mode;
            cnt_d  = '0;
            bdir_d = UP;
            fph_d  = FILL;
        end else if (i_valid) begin
            // ">=" so a lowered i_div steps on the next strobe.
            if (div_cnt >= i_div) begin
                cnt_d  = '0;
                step_d = 1'b1;
                led_d  = step_led;
                if (mode_q == M_BOUNCE) begin
                    if (step_led[NB_LED-1]) bdir_d = DOWN;
                    else if (step_led[0])   bdir_d = UP;
                end
                if (mode_q == M_FILL) begin
                    if (&step_led)       fph_d = CLEAR;
                    else if (~|step_led) fph_d = FILL;
                end
`ifdef LED_WRAP_FLAG_EN
                wrap_d = (step_led == seed(mode_q));
`endif
            end else begin
                cnt_d = div_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_led   <= ONE;
            mode_q  <= M_ROTATE;
            div_cnt <= '0;
            bdir_q  <= UP;
            fph_q   <= FILL;
            o_step  <= 1'b0;
        end else begin
            o_led   <= led_d;
            mode_q  <= mode_d;
            div_cnt <= cnt_d;
            bdir_q  <= bdir_d;
            fph_q   <= fph_d;
            o_step  <= step_d;
        end
    end

`ifdef LED_WRAP_FLAG_EN
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) o_wrap <= 1'b0;
        else            o_wrap <= wrap_d;
    end
`endif

endmodule
